// File: rtl/gmii_tx_pkg.sv
// Shared types, constants and the CRC-32 byte step for the GMII transmit engine.
// No ports: imported by gmii_tx_frame_engine.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  // Reflected CRC-32, one byte per call, LSB of data first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_frame_buf.sv
// Frame buffer: simple dual-port RAM, DEPTH x 9 bits ({tlast, data}),
// one-cycle registered read, no reset so it maps onto block RAM.
// Ports:
//   clk        clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  {tlast, byte}
//   i_rd_addr  read address (sampled every cycle)
//   o_rd_data  word at i_rd_addr, one cycle later
module gmii_tx_frame_buf #(
  parameter  int DEPTH = 8192,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [8:0]    i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [8:0]    o_rd_data
);

  logic [8:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/gmii_tx_frame_engine.sv
// Store-and-forward GMII transmitter. AXI-Stream bytes are buffered; a frame
// becomes visible to the transmitter only once its good tlast is accepted.
// Bad or oversize frames are rolled back. Frames leave with preamble/SFD,
// zero padding, CRC-32 FCS and a programmable inter-frame gap.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_t{data,valid,last,user}, s_axis_tready   frame input
//   ifg_delay                  idle cycles between frames (sampled on IFG entry)
//   gmii_txd/tx_en/tx_er       registered GMII outputs
//   start_packet               pulse with the first preamble byte
//   stat_overflow              pulse when a frame is dropped for lack of space
//   stat_tx_frames, stat_drop_frames   wrapping frame counters
module gmii_tx_frame_engine
  import gmii_tx_pkg::*;
#(
  parameter int DEPTH            = 8192,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int ENABLE_PADDING   = 1,
  parameter int ENABLE_FCS       = 1,
  parameter int USER_WIDTH       = 1,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic [7:0]            ifg_delay,
  output logic [7:0]            gmii_txd,
  output logic                  gmii_tx_en,
  output logic                  gmii_tx_er,
  output logic                  start_packet,
  output logic                  stat_overflow,
  output logic [CNT_WIDTH-1:0]  stat_tx_frames,
  output logic [CNT_WIDTH-1:0]  stat_drop_frames
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int LW = AW + 2;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH  = PW'(DEPTH);
  localparam logic [LW-1:0] LEN_ONE    = LW'(1);
  localparam logic [LW-1:0] PAD_TARGET = LW'(MIN_FRAME_LENGTH - 4);

  // write side
  logic                 r_tready, r_drop, r_stat_overflow;
  logic [PW-1:0]        r_wr_cur, r_wr_commit;
  logic [CNT_WIDTH-1:0] r_stat_drop;
  logic                 w_beat, w_full, w_drop;

  // read side
  state_t               r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt, w_ifg_load;
  logic [LW-1:0]        r_len, w_len_nxt;
  logic [31:0]          r_crc, w_crc_nxt, w_fcs;
  logic [PW-1:0]        r_rd_ptr, w_rd_ptr_nxt;
  logic [8:0]           w_rd_q;
  logic [7:0]           w_txd, r_txd;
  logic                 w_tx_en, r_tx_en, w_start, r_start, w_tx_done;
  logic [CNT_WIDTH-1:0] r_stat_tx;

  assign w_beat = s_axis_tvalid & r_tready;
  // Buffer is full when the writer is a whole buffer ahead of the reader.
  assign w_full = (r_wr_cur - r_rd_ptr) == PTR_DEPTH;
  assign w_drop = r_drop | w_full;

  gmii_tx_frame_buf #(.DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .i_wr_en   (w_beat & ~w_drop),
    .i_wr_addr (r_wr_cur[AW-1:0]),
    .i_wr_data ({s_axis_tlast, s_axis_tdata}),
    .i_rd_addr (w_rd_ptr_nxt[AW-1:0]),
    .o_rd_data (w_rd_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tready        <= 1'b0;
      r_drop          <= 1'b0;
      r_stat_overflow <= 1'b0;
      r_wr_cur        <= '0;
      r_wr_commit     <= '0;
      r_stat_drop     <= '0;
    end else begin
      r_tready        <= 1'b1;
      r_stat_overflow <= 1'b0;
      if (w_beat) begin
        if (s_axis_tlast) begin
          r_drop <= 1'b0;
          if (w_drop) begin
            r_wr_cur        <= r_wr_commit;
            r_stat_overflow <= 1'b1;
            r_stat_drop     <= r_stat_drop + 1'b1;
          end else if (s_axis_tuser[0]) begin
            r_wr_cur    <= r_wr_commit;
            r_stat_drop <= r_stat_drop + 1'b1;
          end else begin
            r_wr_cur    <= r_wr_cur + PTR_ONE;
            r_wr_commit <= r_wr_cur + PTR_ONE;
          end
        end else if (w_drop) begin
          r_drop <= 1'b1;
        end else begin
          r_wr_cur <= r_wr_cur + PTR_ONE;
        end
      end
    end
  end

  assign w_ifg_load = (ifg_delay == 8'd0) ? 8'd1 : ifg_delay;
  assign w_fcs      = ~r_crc;

  // The byte produced in each state is registered onto GMII at the next edge.
  // The RAM is addressed with the next read pointer so its output already
  // holds the byte to send when PAYLOAD begins and on every following cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_crc_nxt    = r_crc;
    w_rd_ptr_nxt = r_rd_ptr;
    w_txd        = 8'h00;
    w_tx_en      = 1'b0;
    w_start      = 1'b0;
    w_tx_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_rd_ptr != r_wr_commit) begin
          w_txd       = PREAMBLE_BYTE;
          w_tx_en     = 1'b1;
          w_start     = 1'b1;
          w_cnt_nxt   = 8'd1;
          w_len_nxt   = '0;
          w_crc_nxt   = CRC32_INIT;
          w_state_nxt = ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        w_tx_en   = 1'b1;
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'd7) begin
          w_txd       = SFD_BYTE;
          w_state_nxt = ST_PAYLOAD;
        end else begin
          w_txd = PREAMBLE_BYTE;
        end
      end
      ST_PAYLOAD, ST_PAD: begin
        w_tx_en   = 1'b1;
        w_txd     = (r_state == ST_PAYLOAD) ? w_rd_q[7:0] : 8'h00;
        w_crc_nxt = crc32_byte(r_crc, w_txd);
        w_len_nxt = r_len + LEN_ONE;
        if (r_state == ST_PAYLOAD) w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        if ((r_state == ST_PAYLOAD && w_rd_q[8] && ENABLE_PADDING != 0 && w_len_nxt < PAD_TARGET))
          w_state_nxt = ST_PAD;
        else if ((r_state == ST_PAYLOAD && w_rd_q[8]) || (r_state == ST_PAD && w_len_nxt >= PAD_TARGET)) begin
          if (ENABLE_FCS != 0) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = ST_FCS;
          end else begin
            w_cnt_nxt   = w_ifg_load;
            w_tx_done   = 1'b1;
            w_state_nxt = ST_IFG;
          end
        end
      end
      ST_FCS: begin
        w_tx_en   = 1'b1;
        w_txd     = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
        w_cnt_nxt = r_cnt + 8'd1;
        if (r_cnt == 8'd3) begin
          w_cnt_nxt   = w_ifg_load;
          w_tx_done   = 1'b1;
          w_state_nxt = ST_IFG;
        end
      end
      ST_IFG: begin
        // Counts down to zero inclusive: the extra cycle is the idle turn
        // that always separates two frames.
        if (r_cnt == 8'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_crc     <= CRC32_INIT;
      r_rd_ptr  <= '0;
      r_txd     <= 8'h00;
      r_tx_en   <= 1'b0;
      r_start   <= 1'b0;
      r_stat_tx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_crc    <= w_crc_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_txd    <= w_txd;
      r_tx_en  <= w_tx_en;
      r_start  <= w_start;
      if (w_tx_done) r_stat_tx <= r_stat_tx + 1'b1;
    end
  end

  assign s_axis_tready    = r_tready;
  assign gmii_txd         = r_txd;
  assign gmii_tx_en       = r_tx_en;
  assign gmii_tx_er       = 1'b0;
  assign start_packet     = r_start;
  assign stat_overflow    = r_stat_overflow;
  assign stat_tx_frames   = r_stat_tx;
  assign stat_drop_frames = r_stat_drop;

endmodule

// File: doc/gmii_tx_frame_engine.md
# gmii_tx_frame_engine

Store-and-forward GMII transmit engine with an integrated frame buffer. It takes an 8-bit AXI-Stream frame and drops it if it is flagged bad or does not fit in the buffer. Complete frames go out on GMII with preamble/SFD, zero padding, a generated FCS and a runtime-programmable inter-frame gap. It sits between packet-generation logic and the GMII PHY interface, and it exports frame statistics for the speed-test control plane.

## Interface
- DEPTH, 8192: buffer depth in bytes; power of two, at least 64.
- MIN_FRAME_LENGTH, 64: minimum frame length in bytes, FCS included.
- ENABLE_PADDING, 1: pad short frames with 0x00 up to MIN_FRAME_LENGTH.
- ENABLE_FCS, 1: append the 4-byte CRC-32 FCS; when 0, pad target is MIN_FRAME_LENGTH-4 and no FCS is sent.
- USER_WIDTH, 1: tuser width; bit 0 is the bad-frame flag.
- CNT_WIDTH, 32: width of the statistics counters.
- clk  in  1  single clock domain.
- rst_n  in  1  asynchronous reset, active-low.
- s_axis_tdata  in  8  frame byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  reset value 0; 1 whenever out of reset.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  USER_WIDTH  bit 0 = 1 on the tlast beat drops the frame.
- ifg_delay  in  8  IFG in idle cycles; sampled on entry to IFG.
- gmii_txd  out  8  registered; reset value 0x00.
- gmii_tx_en  out  1  registered; reset value 0.
- gmii_tx_er  out  1  constant 0; underflow cannot occur.
- start_packet  out  1  one-cycle pulse when the first preamble byte is driven; reset value 0.
- stat_overflow  out  1  one-cycle pulse when a frame is dropped for lack of space; reset value 0.
- stat_tx_frames  out  CNT_WIDTH  frames transmitted; wraps; reset value 0.
- stat_drop_frames  out  CNT_WIDTH  frames dropped for any reason; wraps; reset value 0.

## Operation
- Write side: bytes are written at wr_cur. Each RAM word is 9 bits: {tlast, data}.
  - Pointers are log2(DEPTH)+1 bits: wr_commit, wr_cur, rd_ptr.
  - On a good tlast, wr_commit <= wr_cur+1.
  - On a tlast with tuser[0]=1, wr_cur <= wr_commit (rollback) and stat_drop_frames increments.
- Overflow: a byte arriving while wr_cur - rd_ptr == DEPTH sets drop mode.
  - In drop mode, the rest of the frame is accepted and discarded.
  - On its tlast: rollback, stat_overflow pulses, stat_drop_frames increments. Drop counts once per frame.
- Read FSM, states IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG:
  - IDLE -> PREAMBLE when rd_ptr != wr_commit.
  - PREAMBLE: drive 0x55 seven times, then 0xD5. The RAM is prefetched in this state.
  - PAYLOAD: drive bytes until the stored tlast. Then go to PAD if ENABLE_PADDING and length < target, else to FCS if ENABLE_FCS, else to IFG.
  - PAD: drive 0x00 until length == target.
  - FCS: drive ~crc, LSB byte first, 4 cycles.
  - IFG: hold tx_en=0 for max(ifg_delay,1) cycles, then go to IDLE.
- CRC-32 uses reflected polynomial 0xEDB88320 with init 0xFFFFFFFF. It covers payload and pad bytes, not preamble.
- stat_tx_frames increments on the last cycle with tx_en=1.

## Timing
- tlast accepted at edge N: the frame is committed after N. gmii_tx_en=1 and txd=0x55 are driven after edge N+1; start_packet is high in that same cycle.
- Frame on the wire: tx_en contiguous for 8 + max(len, target) + 4·ENABLE_FCS cycles.
- Back-to-back frames: tx_en gap is exactly max(ifg_delay,1) cycles plus 1 IDLE cycle. ifg_delay is not re-sampled during IFG.
- Simultaneous commit and read, or rollback and read, in the same cycle are legal. The read side only ever sees committed data.
- Reset asserted mid-frame: all outputs go to their reset values asynchronously. Buffered and partial frames are lost. After deassert the FSM is in IDLE with the buffer empty.

## Structure
- Package gmii_tx_pkg holds:
  - the state_t enum,
  - PREAMBLE_BYTE (0x55), SFD_BYTE (0xD5), CRC32_POLY, CRC32_INIT,
  - function crc32_byte(crc, data).
- Sub-module gmii_tx_frame_buf: simple dual-port RAM, DEPTH×9, one-cycle read latency, inferred BRAM. Pointer and commit logic stay in the top.

## Test plan
- 60-byte frame 0x00..0x3B, ifg_delay=12 -> 0x55×7, 0xD5, the 60 bytes, then an FCS equal to a software CRC-32. tx_en high for 72 cycles; stat_tx_frames=1.
- 14-byte frame -> 46 pad bytes of 0x00 after the data, FCS computed over 60 bytes, tx_en high for 72 cycles. With ENABLE_PADDING=0: tx_en high for 26 cycles.
- 30-byte frame with tuser[0]=1 on tlast, then a good 64-byte frame -> only the second frame is transmitted; stat_drop_frames=1, stat_tx_frames=1.
- Two queued frames with ifg_delay=12 -> exactly 13 cycles with tx_en=0 between them. With ifg_delay=0 -> 2 cycles.
- DEPTH=64, 100-byte frame then a 20-byte frame -> one stat_overflow pulse; the first frame never appears on GMII; the second is sent padded to 64 bytes.
- rst_n low mid-payload -> txd=0x00 and tx_en=0 immediately, all statistics 0. After release there is no GMII activity until a new frame is written.
